// File: rtl/pokey_chan_divider.sv
`default_nettype none
// ============================================================================
//  Module      : pokey_chan_divider
//  Description : POKEY-style audio channel divider. Latches a frequency
//                divisor from the data bus, down-counts on count requests,
//                generates the borrow, its own reload strobe, a one-cycle
//                channel pulse and a square-wave toggle output.
//                All state changes on the falling edge of clk, gated by enn.
//  Options     : `define CHAN_LINK_EN to count only when the lower channel
//                borrows (nBOR_in low), so two instances form a 16-bit divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module pokey_chan_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enn,
  input  logic [WIDTH-1:0] D,
  input  logic             WR,
  input  logic             CR,
  input  logic             FRC,
  input  logic             nBOR_in,
  output logic             nBOR,
  output logic [WIDTH-1:0] CNT,
  output logic             CHOUT,
  output logic             TGL
);

  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] audf;
  logic [WIDTH-1:0] cnt;
  logic             ld;
  logic             tgl;

  logic             cr_eff;
  logic             cnt_zero;
  logic             bor;

`ifdef CHAN_LINK_EN
  // Linked mode: count only when the lower channel signals its borrow.
  assign cr_eff = CR & ~nBOR_in;
`else
  // Standalone mode: the borrow input is present but has no effect.
  logic unused_nbor_in;
  assign unused_nbor_in = nBOR_in;
  assign cr_eff         = CR;
`endif

  assign cnt_zero = (cnt == C_ZERO);

  // A borrow is a count request arriving at zero while no reload is pending.
  assign bor  = ~ld & cr_eff & cnt_zero;
  assign nBOR = ~bor;

  assign CNT   = cnt;
  assign CHOUT = ld;
  assign TGL   = tgl;

  // Divisor register; only consulted at a reload, so a running count is untouched.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      audf <= C_ZERO;
    end else if (enn && WR) begin
      audf <= D;
    end
  end

  // Counter, reload-pending flag and toggle, in strict priority order.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      cnt <= C_ZERO;
      ld  <= 1'b0;
      tgl <= 1'b0;
    end else if (enn) begin
      if (ld) begin
        // Reload cycle: pre-write audf is used, count request is ignored.
        cnt <= audf;
        ld  <= 1'b0;
        tgl <= ~tgl;
      end else if (FRC) begin
        ld  <= 1'b1;
      end else if (cr_eff) begin
        if (cnt_zero) begin
          cnt <= C_ALL_ONES;
          ld  <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
